systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_ctrl_if.sv | 24 ++
 rtl/systolic_ctrl.sv | 132 +++++++++++++
 tb/tb_systolic_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/systolic_ctrl_if.sv
// Host-side handshake bundle for systolic_ctrl: job request, weight-row and
// feature-vector handshakes, and job status.
interface systolic_ctrl_if #(
  parameter int unsigned LEN_W = 16
) ();
  logic             start;
  logic [LEN_W-1:0] fm_len;
  logic             w_valid;
  logic             w_ready;
  logic             fm_valid;
  logic             fm_ready;
  logic             busy;
  logic             done;

  modport master (
    output start, fm_len, w_valid, fm_valid,
    input  w_ready, fm_ready, busy, done
  );

  modport slave (
    input  start, fm_len, w_valid, fm_valid,
    output w_ready, fm_ready, busy, done
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for an ARRAY_N x ARRAY_N weight-stationary systolic array: weight load,
// swap, skewed feature streaming, drain. Optional perf counters: SYSTOLIC_CTRL_PERF_CNT_EN.
module systolic_ctrl #(
  parameter int unsigned ARRAY_N = 4,
  parameter int unsigned LEN_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  systolic_ctrl_if.slave     bus,
  output logic               arr_load_en,
  output logic               arr_shift_en,
  output logic [ARRAY_N-1:0] fm_row_valid,
  output logic [ARRAY_N-1:0] psum_col_valid
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]        perf_busy_cyc,
  output logic [31:0]        perf_stall_cyc
`endif
);

  localparam int unsigned ROW_W  = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1;
  localparam int unsigned DRN_W  = $clog2(2 * ARRAY_N + 1);
  localparam int unsigned PIPE_D = 2 * ARRAY_N;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SWAP   = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t             state, state_nx;
  logic [LEN_W-1:0]   fm_len_q;
  logic [ROW_W-1:0]   row_cnt;
  logic [LEN_W-1:0]   vec_cnt;
  logic [DRN_W-1:0]   drn_cnt;
  logic [PIPE_D:1]    acc_sr;
  logic               fm_acc;
  logic               start_acc;

  assign start_acc   = (state == S_IDLE) && bus.start;
  assign arr_load_en = bus.w_valid & bus.w_ready;
  assign fm_acc      = bus.fm_valid & bus.fm_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; vector compare against fm_len-1 avoids wrap at max length
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (bus.start) state_nx = S_LOAD;
      S_LOAD:   if (arr_load_en && (row_cnt == ROW_W'(ARRAY_N - 1))) state_nx = S_SWAP;
      S_SWAP:   state_nx = (fm_len_q == '0) ? S_DONE : S_STREAM;
      S_STREAM: if (fm_acc && (vec_cnt == fm_len_q - LEN_W'(1))) state_nx = S_DRAIN;
      S_DRAIN:  if (drn_cnt == DRN_W'(2 * ARRAY_N)) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    bus.w_ready  = 1'b0;
    bus.fm_ready = 1'b0;
    bus.done     = 1'b0;
    arr_shift_en = 1'b0;
    bus.busy     = (state != S_IDLE);
    case (state)
      S_LOAD:   bus.w_ready  = 1'b1;
      S_SWAP:   arr_shift_en = 1'b1;
      S_STREAM: bus.fm_ready = 1'b1;
      S_DONE:   bus.done     = 1'b1;
      default:  ;
    endcase
  end

  // Job length latch and row / vector / drain counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fm_len_q <= '0;
      row_cnt  <= '0;
      vec_cnt  <= '0;
      drn_cnt  <= '0;
    end else if (start_acc) begin
      fm_len_q <= bus.fm_len;
      row_cnt  <= '0;
      vec_cnt  <= '0;
      drn_cnt  <= '0;
    end else begin
      if (arr_load_en)        row_cnt <= row_cnt + ROW_W'(1);
      if (fm_acc)             vec_cnt <= vec_cnt + LEN_W'(1);
      if (state == S_DRAIN)   drn_cnt <= drn_cnt + DRN_W'(1);
    end
  end

  // acc_sr[k] is the accept strobe delayed by k cycles
  always_ff @(posedge clk) begin
    if (!rst_n) acc_sr <= '0;
    else        acc_sr <= {acc_sr[PIPE_D-1:1], fm_acc};
  end

  // Row r sees the accept r cycles late; column c result lands ARRAY_N+1+c cycles late
  always_comb begin
    fm_row_valid    = '0;
    psum_col_valid  = '0;
    fm_row_valid[0] = fm_acc;
    for (int r = 1; r < ARRAY_N; r++) fm_row_valid[r] = acc_sr[r];
    for (int c = 0; c < ARRAY_N; c++) psum_col_valid[c] = acc_sr[ARRAY_N + 1 + c];
  end

`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
  // Saturating busy / stall counters, cleared per job
  always_ff @(posedge clk) begin
    if (!rst_n || start_acc) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (bus.busy && (perf_busy_cyc != '1))
        perf_busy_cyc <= perf_busy_cyc + 32'd1;
      if ((state == S_STREAM) && !bus.fm_valid && (perf_stall_cyc != '1))
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed self-checking bench for systolic_ctrl (ARRAY_N=4, LEN_W=4 so the
// maximum-length job stays short). Perf checks compile in with SYSTOLIC_CTRL_PERF_CNT_EN.
module tb_systolic_ctrl;
  localparam int unsigned ARRAY_N = 4;
  localparam int unsigned LEN_W   = 4;

  logic clk;
  logic rst_n;
  logic               arr_load_en;
  logic               arr_shift_en;
  logic [ARRAY_N-1:0] fm_row_valid;
  logic [ARRAY_N-1:0] psum_col_valid;
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
  logic [31:0] perf_busy_cyc;
  logic [31:0] perf_stall_cyc;
`endif

  systolic_ctrl_if #(.LEN_W(LEN_W)) bus ();

  systolic_ctrl #(.ARRAY_N(ARRAY_N), .LEN_W(LEN_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .arr_load_en    (arr_load_en),
    .arr_shift_en   (arr_shift_en),
    .fm_row_valid   (fm_row_valid),
    .psum_col_valid (psum_col_valid)
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    ,
    .perf_busy_cyc  (perf_busy_cyc),
    .perf_stall_cyc (perf_stall_cyc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int cyc_no, n_load, n_shift, n_acc, n_done, n_psum, n_row, n_fmrdy;
  int t_first_acc, t_last_acc, t_done, t_shift, t_last_load, t_row3, t_psum0, t_psum3;
  int p_busy_at_done, p_stall_at_done;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    cyc_no = 0; n_load = 0; n_shift = 0; n_acc = 0; n_done = 0; n_psum = 0; n_row = 0;
    n_fmrdy = 0; t_first_acc = -1; t_last_acc = -1; t_done = -1; t_shift = -1;
    t_last_load = -1; t_row3 = -1; t_psum0 = -1; t_psum3 = -1;
    p_busy_at_done = -1; p_stall_at_done = -1;
  endtask

  task automatic sample();
    if (arr_load_en)  begin n_load++;  t_last_load = cyc_no; end
    if (arr_shift_en) begin n_shift++; t_shift = cyc_no; end
    if (bus.fm_ready) n_fmrdy++;
    if (bus.fm_valid && bus.fm_ready) begin
      n_acc++;
      if (t_first_acc < 0) t_first_acc = cyc_no;
      t_last_acc = cyc_no;
    end
    if (bus.done) begin
      n_done++;
      t_done = cyc_no;
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
      p_busy_at_done  = int'(perf_busy_cyc);
      p_stall_at_done = int'(perf_stall_cyc);
`endif
    end
    n_psum += $countones(psum_col_valid);
    n_row  += $countones(fm_row_valid);
    if (fm_row_valid[3]   && t_row3  < 0) t_row3  = cyc_no;
    if (psum_col_valid[0] && t_psum0 < 0) t_psum0 = cyc_no;
    if (psum_col_valid[3] && t_psum3 < 0) t_psum3 = cyc_no;
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  int'(bus.busy), 0);
    chk({tag, "_done"},  int'(bus.done), 0);
    chk({tag, "_wrdy"},  int'(bus.w_ready), 0);
    chk({tag, "_frdy"},  int'(bus.fm_ready), 0);
    chk({tag, "_load"},  int'(arr_load_en), 0);
    chk({tag, "_shift"}, int'(arr_shift_en), 0);
    chk({tag, "_rowv"},  int'(fm_row_valid), 0);
    chk({tag, "_psumv"}, int'(psum_col_valid), 0);
  endtask

  // One full job: start in cycle 0, optional w_valid toggling, leading stalls in STREAM
  task automatic run_job(input string tag, input int len, input bit w_toggle,
                         input int stalls, input bit start_again);
    bit ph;
    int stalls_left;
    int k;
    clr_stats();
    bus.start = 1'b1; bus.fm_len = LEN_W'(len); bus.w_valid = 1'b1; bus.fm_valid = 1'b1;
    step();
    bus.start = start_again;
    ph = 1'b1; stalls_left = stalls; k = 0;
    while (n_done == 0 && k < 200) begin
      bus.w_valid = w_toggle ? ph : 1'b1;
      ph = ~ph;
      if (bus.fm_ready && stalls_left > 0) begin
        bus.fm_valid = 1'b0; stalls_left--;
      end else begin
        bus.fm_valid = 1'b1;
      end
      step();
      bus.start = 1'b0;
      k++;
    end
    chk({tag, "_finished"}, int'(n_done > 0), 1);
    chk({tag, "_loads"},  n_load, 4);
    chk({tag, "_shifts"}, n_shift, 1);
    chk({tag, "_swap_after_last_load"}, t_shift, t_last_load + 1);
    chk({tag, "_accepts"}, n_acc, len);
    chk({tag, "_row_pulses"}, n_row, 4 * len);
    chk({tag, "_psum_pulses"}, n_psum, 4 * len);
    if (len > 0) chk({tag, "_drain_len"}, t_done - t_last_acc - 1, 9);
    else begin
      chk({tag, "_done_after_swap"}, t_done, t_shift + 1);
      chk({tag, "_fm_ready_cycles"}, n_fmrdy, 0);
    end
    step();
    step();
    chk({tag, "_done_pulses"}, n_done, 1);
    chk({tag, "_idle_after"}, int'(bus.busy), 0);
  endtask

  initial begin
    clr_stats();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.fm_len = '0; bus.w_valid = 1'b1; bus.fm_valid = 1'b1;
    step();
    step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();
    chk_all_zero("post_reset_idle");

    // Basic job: fm_len=3, valids held high; start re-pulsed while busy must be ignored
    run_job("job3", 3, 1'b0, 0, 1'b1);
    chk("job3_first_acc", t_first_acc, 6);
    chk("job3_row3_skew", t_row3, t_first_acc + 3);
    chk("job3_psum0_lat", t_psum0, t_first_acc + 5);
    chk("job3_psum3_lat", t_psum3, t_first_acc + 8);

    run_job("wtoggle", 2, 1'b1, 0, 1'b0);
    chk("wtoggle_last_load", t_last_load, 7);

    run_job("len0", 0, 1'b0, 0, 1'b0);

    run_job("stall", 3, 1'b0, 2, 1'b0);
    chk("stall_first_acc", t_first_acc, 8);

    run_job("maxlen", 15, 1'b0, 0, 1'b0);

    // Reset in the middle of STREAM, then a fresh job
    clr_stats();
    bus.start = 1'b1; bus.fm_len = LEN_W'(5); bus.w_valid = 1'b1; bus.fm_valid = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 50 && n_acc < 2; i++) step();
    chk("midrst_reached_stream", n_acc, 2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_all_zero("midrst");
    step();
    chk_all_zero("midrst_idle");
    run_job("after_rst", 2, 1'b0, 0, 1'b0);

`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    run_job("perf", 2, 1'b0, 3, 1'b0);
    chk("perf_stall_at_done", p_stall_at_done, 3);
    chk("perf_busy_at_done", p_busy_at_done, 19);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
